// File: rtl/mem_access_unit.sv
// Load/store unit between a byte-addressed request port and a doubleword data memory.
// Sub-double stores use a read-modify-write. Misaligned requests complete as faults and never touch memory.
module mem_access_unit #(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [1:0]  ReqSize,
    input  logic        ReqSigned,
    input  logic [63:0] ReqAddress,
    input  logic [63:0] ReqWriteData,
    output logic        RespValid,
    output logic [63:0] RespData,
    output logic        Misaligned,
    output logic [63:0] Address,
    output logic [63:0] WriteData,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [63:0] ReadData
);

    // Handshake: a request transfers on a rising edge where ReqValid && ReqReady.
    // ReqReady is high only in IDLE. RespValid is a one-cycle pulse that needs no acknowledge.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        RWAIT = 3'd2,
        WR    = 3'd3,
        DONE  = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [2:0]  off_q, off_d;
    logic [63:0] wdata_q, wdata_d;
    logic        fault_q, fault_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wrdata_q, wrdata_d;
    logic [63:0] resp_data_q, resp_data_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        req_aligned;
    logic [5:0]  lane_shift;
    logic [63:0] lane;
    logic [63:0] load_data;
    logic [63:0] size_mask;
    logic [63:0] merged;

    always_comb begin
        req_aligned = 1'b1;
        unique case (ReqSize)
            2'b00: req_aligned = 1'b1;
            2'b01: req_aligned = ~ReqAddress[0];
            2'b10: req_aligned = (ReqAddress[1:0] == 2'b00);
            2'b11: req_aligned = (ReqAddress[2:0] == 3'b000);
            default: req_aligned = 1'b1;
        endcase
    end

    assign lane_shift = {off_q, 3'b000};
    assign lane       = ReadData >> lane_shift;

    // Load extraction from the live ReadData; only consumed on the final RWAIT edge.
    always_comb begin
        load_data = lane;
        unique case (size_q)
            2'b00: load_data = signed_q ? {{56{lane[7]}}, lane[7:0]}   : {56'b0, lane[7:0]};
            2'b01: load_data = signed_q ? {{48{lane[15]}}, lane[15:0]} : {48'b0, lane[15:0]};
            2'b10: load_data = signed_q ? {{32{lane[31]}}, lane[31:0]} : {32'b0, lane[31:0]};
            2'b11: load_data = ReadData;
            default: load_data = ReadData;
        endcase
    end

    always_comb begin
        size_mask = 64'h0000_0000_0000_00FF;
        unique case (size_q)
            2'b00: size_mask = 64'h0000_0000_0000_00FF;
            2'b01: size_mask = 64'h0000_0000_0000_FFFF;
            2'b10: size_mask = 64'h0000_0000_FFFF_FFFF;
            2'b11: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
            default: size_mask = 64'h0000_0000_0000_00FF;
        endcase
    end

    assign merged = (ReadData & ~(size_mask << lane_shift))
                  | ((wdata_q & size_mask) << lane_shift);

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        size_d      = size_q;
        signed_d    = signed_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        fault_d     = fault_q;
        addr_d      = addr_q;
        wrdata_d    = wrdata_q;
        resp_data_d = resp_data_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (ReqValid) begin
                    write_d  = ReqWrite;
                    size_d   = ReqSize;
                    signed_d = ReqSigned;
                    off_d    = ReqAddress[2:0];
                    wdata_d  = ReqWriteData;
                    fault_d  = ~req_aligned;
                    addr_d   = {3'b000, ReqAddress[63:3]};
                    if (!req_aligned) begin
                        state_d     = DONE;
                        resp_data_d = 64'b0;
                    end else if (ReqWrite && (ReqSize == 2'b11)) begin
                        state_d  = WR;
                        wrdata_d = ReqWriteData;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                state_d = RWAIT;
                cnt_d   = 4'(LATENCY);
            end
            RWAIT: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d = 4'd0;
                    if (write_q) begin
                        state_d  = WR;
                        wrdata_d = merged;
                    end else begin
                        state_d     = DONE;
                        resp_data_d = load_data;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WR: begin
                state_d     = DONE;
                resp_data_d = 64'b0;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            off_q       <= 3'b000;
            wdata_q     <= 64'b0;
            fault_q     <= 1'b0;
            addr_q      <= 64'b0;
            wrdata_q    <= 64'b0;
            resp_data_q <= 64'b0;
            cnt_q       <= 4'd0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            fault_q     <= fault_d;
            addr_q      <= addr_d;
            wrdata_q    <= wrdata_d;
            resp_data_q <= resp_data_d;
            cnt_q       <= cnt_d;
        end
    end

    // Strobes and the response pulse decode straight from state so reset kills them at once.
    assign ReqReady   = (state_q == IDLE);
    assign MemRead    = (state_q == RD);
    assign MemWrite   = (state_q == WR);
    assign RespValid  = (state_q == DONE);
    assign Misaligned = (state_q == DONE) && fault_q;
    assign Address    = addr_q;
    assign WriteData  = wrdata_q;
    assign RespData   = resp_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: one instance with LATENCY=1 on a small memory model,
// one with LATENCY=3 whose ReadData is steered cycle by cycle.
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        rv1, rv3;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;

    logic        rr1, resp_v1, mis1, mr1, mw1;
    logic [63:0] resp_d1, addr1, wd1, rd1;
    logic        rr3, resp_v3, mis3, mr3, mw3;
    logic [63:0] resp_d3, addr3, wd3, rd3;

    logic [63:0] mem1 [8];
    assign rd1 = mem1[addr1[2:0]];

    int total = 0;
    int bad   = 0;

    int          r_lat, r_nrd, r_nwr, r_both;
    logic [63:0] r_rd_addr, r_wr_addr, r_wr_data, r_resp;
    logic        r_mis;

    mem_access_unit #(.LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .ReqValid(rv1), .ReqReady(rr1), .ReqWrite(req_write), .ReqSize(req_size),
        .ReqSigned(req_signed), .ReqAddress(req_addr), .ReqWriteData(req_wdata),
        .RespValid(resp_v1), .RespData(resp_d1), .Misaligned(mis1),
        .Address(addr1), .WriteData(wd1), .MemRead(mr1), .MemWrite(mw1), .ReadData(rd1)
    );

    mem_access_unit #(.LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .ReqValid(rv3), .ReqReady(rr3), .ReqWrite(req_write), .ReqSize(req_size),
        .ReqSigned(req_signed), .ReqAddress(req_addr), .ReqWriteData(req_wdata),
        .RespValid(resp_v3), .RespData(resp_d3), .Misaligned(mis3),
        .Address(addr3), .WriteData(wd3), .MemRead(mr3), .MemWrite(mw3), .ReadData(rd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request to the LATENCY=1 instance and watch it to completion.
    // Window n is the cycle between edge accept+n-1 and accept+n; r_lat is the window holding RespValid.
    task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [63:0] a, input logic [63:0] wd);
        logic got;
        check("ready_before_req", {63'b0, rr1}, 64'd1);
        req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        rv1 = 1'b1;
        tick();
        rv1 = 1'b0;
        req_write = ~w; req_size = ~sz; req_signed = ~sg;
        req_addr = 64'hFFFF_FFFF_FFFF_FFF8; req_wdata = ~wd;
        r_lat = 0; r_nrd = 0; r_nwr = 0; r_both = 0; got = 1'b0;
        r_rd_addr = '0; r_wr_addr = '0; r_wr_data = '0; r_resp = '0; r_mis = 1'b0;
        for (int n = 1; n <= 20 && !got; n++) begin
            if (mr1) begin r_nrd++; r_rd_addr = addr1; end
            if (mw1) begin r_nwr++; r_wr_addr = addr1; r_wr_data = wd1; end
            if (mr1 && mw1) r_both++;
            if (resp_v1) begin
                got = 1'b1; r_lat = n; r_resp = resp_d1; r_mis = mis1;
            end else begin
                tick();
            end
        end
        tick();
        check("resp_one_cycle", {63'b0, resp_v1}, 64'd0);
        check("resp_data_hold", resp_d1, r_resp);
    endtask

    initial begin
        int seen;
        int lat3;
        reset = 1'b1; rv1 = 1'b0; rv3 = 1'b0;
        req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        rd3 = '0;
        for (int i = 0; i < 8; i++) mem1[i] = 64'h0;
        mem1[2] = 64'h8877_6655_4433_2211;

        tick(); tick();
        check("rst_ready",     {63'b0, rr1},     64'd1);
        check("rst_respvalid", {63'b0, resp_v1}, 64'd0);
        check("rst_memread",   {63'b0, mr1},     64'd0);
        check("rst_memwrite",  {63'b0, mw1},     64'd0);
        check("rst_misaligned",{63'b0, mis1},    64'd0);
        check("rst_respdata",  resp_d1,          64'd0);
        check("rst_address",   addr1,            64'd0);
        check("rst_writedata", wd1,              64'd0);
        reset = 1'b0;
        tick();

        // Double load; ReqSigned=1 must be ignored.
        run_req(1'b0, 2'b11, 1'b1, 64'h10, 64'h0);
        check("dload_lat",   64'(r_lat), 64'd3);
        check("dload_nrd",   64'(r_nrd), 64'd1);
        check("dload_nwr",   64'(r_nwr), 64'd0);
        check("dload_addr",  r_rd_addr,  64'd2);
        check("dload_data",  r_resp,     64'h8877_6655_4433_2211);
        check("dload_mis",   {63'b0, r_mis}, 64'd0);

        run_req(1'b0, 2'b00, 1'b0, 64'h17, 64'h0);
        check("lbu_17", r_resp, 64'h88);
        run_req(1'b0, 2'b00, 1'b1, 64'h17, 64'h0);
        check("lb_17", r_resp, 64'hFFFF_FFFF_FFFF_FF88);
        run_req(1'b0, 2'b00, 1'b1, 64'h13, 64'h0);
        check("lb_13", r_resp, 64'h44);
        run_req(1'b0, 2'b01, 1'b1, 64'h16, 64'h0);
        check("lh_16", r_resp, 64'hFFFF_FFFF_FFFF_8877);
        run_req(1'b0, 2'b10, 1'b0, 64'h14, 64'h0);
        check("lwu_14", r_resp, 64'h8877_6655);

        // Half store read-modify-write into a zero doubleword.
        run_req(1'b1, 2'b01, 1'b0, 64'h0A, 64'h0000_0000_0000_ABCD);
        check("sh_lat",    64'(r_lat),  64'd4);
        check("sh_nrd",    64'(r_nrd),  64'd1);
        check("sh_nwr",    64'(r_nwr),  64'd1);
        check("sh_both",   64'(r_both), 64'd0);
        check("sh_rdaddr", r_rd_addr,   64'd1);
        check("sh_wraddr", r_wr_addr,   64'd1);
        check("sh_wdata",  r_wr_data,   64'h0000_0000_ABCD_0000);
        check("sh_resp",   r_resp,      64'd0);

        // Byte store: upper junk in the store data must not leak into other lanes.
        run_req(1'b1, 2'b00, 1'b0, 64'h11, 64'hFFFF_FFFF_FFFF_FF5A);
        check("sb_wdata", r_wr_data, 64'h8877_6655_4433_5A11);
        check("sb_lat",   64'(r_lat), 64'd4);

        run_req(1'b1, 2'b11, 1'b0, 64'h20, 64'h1122_3344_5566_7788);
        check("sd_lat",    64'(r_lat), 64'd2);
        check("sd_nrd",    64'(r_nrd), 64'd0);
        check("sd_nwr",    64'(r_nwr), 64'd1);
        check("sd_wraddr", r_wr_addr,  64'd4);
        check("sd_wdata",  r_wr_data,  64'h1122_3344_5566_7788);

        run_req(1'b0, 2'b10, 1'b0, 64'h06, 64'h0);
        check("fault_lat",  64'(r_lat), 64'd1);
        check("fault_mis",  {63'b0, r_mis}, 64'd1);
        check("fault_nrd",  64'(r_nrd), 64'd0);
        check("fault_nwr",  64'(r_nwr), 64'd0);
        check("fault_resp", r_resp,     64'd0);

        run_req(1'b1, 2'b01, 1'b0, 64'h0B, 64'h1234);
        check("sfault_mis", {63'b0, r_mis}, 64'd1);
        check("sfault_nwr", 64'(r_nwr), 64'd0);

        // Reset in the middle of a load's RWAIT.
        req_write = 1'b0; req_size = 2'b11; req_signed = 1'b0; req_addr = 64'h10;
        rv1 = 1'b1;
        tick();
        rv1 = 1'b0;
        check("rstmid_rd", {63'b0, mr1}, 64'd1);
        tick();
        reset = 1'b1;
        #1;
        check("rstmid_memread", {63'b0, mr1},     64'd0);
        check("rstmid_ready",   {63'b0, rr1},     64'd1);
        check("rstmid_resp",    {63'b0, resp_v1}, 64'd0);
        check("rstmid_addr",    addr1,            64'd0);
        #2;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (resp_v1) seen++;
        end
        check("rstmid_no_resp", 64'(seen), 64'd0);
        run_req(1'b0, 2'b11, 1'b0, 64'h10, 64'h0);
        check("after_rst_lat",  64'(r_lat), 64'd3);
        check("after_rst_data", r_resp, 64'h8877_6655_4433_2211);

        // LATENCY=3: only the value present in the final RWAIT cycle may be captured.
        check("lat3_ready", {63'b0, rr3}, 64'd1);
        req_write = 1'b0; req_size = 2'b11; req_signed = 1'b0; req_addr = 64'h10;
        rv3 = 1'b1;
        tick();
        rv3 = 1'b0;
        lat3 = 0;
        for (int n = 1; n <= 8; n++) begin
            rd3 = (n == 4) ? 64'hCAFE_F00D_1234_5678 : (64'hBAD0_0000_0000_0000 | 64'(n));
            #1;
            if (n == 1) begin
                check("lat3_memread", {63'b0, mr3}, 64'd1);
                check("lat3_addr",    addr3,        64'd2);
            end
            if (resp_v3 && lat3 == 0) lat3 = n;
            tick();
        end
        check("lat3_lat",  64'(lat3), 64'd5);
        check("lat3_data", resp_d3,   64'hCAFE_F00D_1234_5678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
